// File: rtl/mmio_uart_tx_pkg.sv
// rtl/mmio_uart_tx_pkg.sv - register offsets, status bits and FSM states for mmio_uart_tx
package mmio_uart_tx_pkg;

    // Word offsets within the 16-byte register window (data_addr[3:2])
    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_DIV    = 2'd2;

    // STATUS register bit positions
    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        UTX_IDLE,
        UTX_START,
        UTX_DATA,
        UTX_STOP
    } uart_tx_state_t;

    // Bit-timer reload value: max(div,1)-1, so a divisor of 0 acts like 1
    function automatic logic [15:0] bit_reload(input logic [15:0] div);
        return (div == 16'd0) ? 16'd0 : div - 16'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with occupancy count
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, din     write request and data; ignored when full unless pop is also accepted
//   pop, dout     read request; dout always shows the head entry
//   full, empty   occupancy flags
//   count         number of stored entries (0..DEPTH)
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still safe
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   data_addr/wdata/we/re       CPU data-port request
//   data_rdata                  combinational read data, 0 when not selected
//   sel                         address falls in the 16-byte register window
//   uart_tx                     serial line, idle high
//   tx_irq                      FIFO empty and serializer idle (registered)
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_we,
    input  logic        data_re,
    output logic [31:0] data_rdata,
    output logic        sel,
    output logic        uart_tx,
    output logic        tx_irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]     offset;
    logic           wr_txdata;
    logic           wr_ovf_clr;
    logic           fifo_push;
    logic           fifo_pop;
    logic           drop;
    logic [7:0]     fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;

    logic [15:0]    div_q;
    logic           ovf_q;

    uart_tx_state_t state_q;
    logic [15:0]    timer_q;
    logic [15:0]    reload_q;
    logic [2:0]     bit_idx_q;
    logic [7:0]     shift_q;
    logic           tx_q;
    logic           irq_q;

    logic [31:0]    rdata_d;
    logic           unused_bits;

    assign unused_bits = ^{data_addr[1:0], data_wdata[31:16], data_we[3:2]};

    // ---------------- decode ----------------
    assign sel        = (data_addr[31:4] == BASE_ADDR[31:4]);
    assign offset     = data_addr[3:2];
    assign wr_txdata  = sel && (offset == UART_TXDATA) && data_we[0];
    assign wr_ovf_clr = sel && (offset == UART_STATUS) && data_we[0] && data_wdata[ST_OVF];

    // IDLE pops whenever something is queued; the FIFO permits push+pop when full
    assign fifo_pop  = (state_q == UTX_IDLE) && !fifo_empty;
    assign fifo_push = wr_txdata && (!fifo_full || fifo_pop);
    assign drop      = wr_txdata && !fifo_push;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (data_wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ---------------- registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= DEFAULT_DIV;
            ovf_q <= 1'b0;
        end else begin
            if (sel && (offset == UART_DIV) && data_we[0]) div_q[7:0]  <= data_wdata[7:0];
            if (sel && (offset == UART_DIV) && data_we[1]) div_q[15:8] <= data_wdata[15:8];
            // A drop in the same cycle as a clear wins so no overflow is lost
            if (drop)            ovf_q <= 1'b1;
            else if (wr_ovf_clr) ovf_q <= 1'b0;
        end
    end

    // ---------------- serializer ----------------
    // The divisor is latched into reload_q at the pop, so DIV writes only
    // affect the next frame. shift_q moves right so bit 0 is always next out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= UTX_IDLE;
            timer_q   <= '0;
            reload_q  <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            irq_q     <= 1'b1;
        end else begin
            irq_q <= fifo_empty && (state_q == UTX_IDLE);
            case (state_q)
                UTX_IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q  <= fifo_dout;
                        reload_q <= bit_reload(div_q);
                        timer_q  <= bit_reload(div_q);
                        tx_q     <= 1'b0;
                        state_q  <= UTX_START;
                    end
                end
                UTX_START: begin
                    if (timer_q == '0) begin
                        timer_q   <= reload_q;
                        tx_q      <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_idx_q <= '0;
                        state_q   <= UTX_DATA;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                UTX_DATA: begin
                    if (timer_q == '0) begin
                        timer_q <= reload_q;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= UTX_STOP;
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                UTX_STOP: begin
                    if (timer_q == '0) begin
                        tx_q    <= 1'b1;
                        state_q <= UTX_IDLE;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= UTX_IDLE;
                end
            endcase
        end
    end

    assign uart_tx = tx_q;
    assign tx_irq  = irq_q;

    // ---------------- read mux ----------------
    always_comb begin
        rdata_d = '0;
        if (sel && data_re) begin
            case (offset)
                UART_STATUS: begin
                    rdata_d[ST_BUSY]                 = (state_q != UTX_IDLE);
                    rdata_d[ST_FULL]                 = fifo_full;
                    rdata_d[ST_EMPTY]                = fifo_empty;
                    rdata_d[ST_OVF]                  = ovf_q;
                    rdata_d[ST_COUNT_LSB +: 8]       = 8'(fifo_count);
                end
                UART_DIV: rdata_d[15:0] = div_q;
                default:  rdata_d = '0;
            endcase
        end
    end

    assign data_rdata = rdata_d;

endmodule
